// File: rtl/add_sub_cla_pipe.sv
// add_sub_cla_pipe: two's-complement adder/subtractor built from 4-bit
// carry-lookahead groups and split into a 2-stage valid/ready pipeline.
// Stage 1 adds the lower half and registers its carry-out. Stage 2 adds the
// upper half and registers the sum and flags.
//
// Build option: define ADD_SAT_EN to saturate the sum on signed overflow.
// When it is undefined, the sum wraps modulo 2^WIDTH.
//
// Ports:
//   clk, rst_n           clock; synchronous active-low reset
//   in_valid / in_ready  operand beat handshake (in_ready is combinational)
//   sub, a, b            0: a+b, 1: a-b
//   out_valid/out_ready  result beat handshake
//   sum, c_out, ovf      result, unsigned carry (1 = no borrow on sub), overflow
//   zero, neg            sum == 0, sum sign bit
module add_sub_cla_pipe #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int unsigned HW = WIDTH / 2;
  localparam int unsigned NG = HW / 4;

  // Half-width add built from 4-bit lookahead groups; returns {carry, sum}.
  function automatic logic [HW:0] cla_add(input logic [HW-1:0] x,
                                          input logic [HW-1:0] y,
                                          input logic          cin);
    logic [HW-1:0] g, p, s;
    logic [NG:0]   gc;
    logic [3:0]    gg, pp, c4;
    logic          grp_g, grp_p;
    g     = x & y;
    p     = x ^ y;
    s     = '0;
    gc    = '0;
    gc[0] = cin;
    for (int unsigned k = 0; k < NG; k++) begin
      gg    = g[4*k +: 4];
      pp    = p[4*k +: 4];
      c4[0] = gc[k];
      c4[1] = gg[0] | (pp[0] & gc[k]);
      c4[2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & gc[k]);
      c4[3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
            | (pp[2] & pp[1] & pp[0] & gc[k]);
      s[4*k +: 4] = pp ^ c4;
      grp_g = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
            | (pp[3] & pp[2] & pp[1] & gg[0]);
      grp_p = &pp;
      gc[k+1] = grp_g | (grp_p & gc[k]);
    end
    return {gc[NG], s};
  endfunction

  logic             r_s1_valid;
  logic [HW-1:0]    r_s1_sum_lo;
  logic             r_s1_c_lo;
  logic [HW-1:0]    r_s1_a_hi;
  logic [HW-1:0]    r_s1_b_hi;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_sum;
  logic             r_c_out;
  logic             r_ovf;
  logic             r_zero;
  logic             r_neg;

  logic             w_s2_adv;
  logic             w_accept;
  logic [WIDTH-1:0] w_b_eff;
  logic [HW:0]      w_lo;
  logic [HW:0]      w_hi;
  logic [WIDTH-1:0] w_sum_raw;
  logic [WIDTH-1:0] w_sum_fin;
  logic             w_ovf;

  // Handshake: stage 2 advances when its slot is free or being drained.
  assign w_s2_adv = r_s1_valid && (!r_out_valid || out_ready);
  assign in_ready = !r_s1_valid || w_s2_adv;
  assign w_accept = in_valid && in_ready;

  // Subtract is a + ~b + 1; the +1 enters as the lower-half carry-in.
  assign w_b_eff = sub ? ~b : b;
  assign w_lo    = cla_add(a[HW-1:0], w_b_eff[HW-1:0], sub);

  // Stage 1: lower-half sum/carry and the upper operand halves.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_sum_lo <= '0;
      r_s1_c_lo   <= 1'b0;
      r_s1_a_hi   <= '0;
      r_s1_b_hi   <= '0;
    end else begin
      if (w_accept) begin
        r_s1_valid  <= 1'b1;
        r_s1_sum_lo <= w_lo[HW-1:0];
        r_s1_c_lo   <= w_lo[HW];
        r_s1_a_hi   <= a[WIDTH-1:HW];
        r_s1_b_hi   <= w_b_eff[WIDTH-1:HW];
      end else if (w_s2_adv) begin
        r_s1_valid  <= 1'b0;
      end
    end
  end

  // Stage 2 combinational: upper half, overflow from operand/result sign bits.
  assign w_hi      = cla_add(r_s1_a_hi, r_s1_b_hi, r_s1_c_lo);
  assign w_sum_raw = {w_hi[HW-1:0], r_s1_sum_lo};
  assign w_ovf     = (r_s1_a_hi[HW-1] == r_s1_b_hi[HW-1]) &&
                     (w_sum_raw[WIDTH-1] != r_s1_a_hi[HW-1]);

`ifdef ADD_SAT_EN
  // On overflow clamp toward the sign of a (positive max or negative min).
  assign w_sum_fin = !w_ovf ? w_sum_raw :
                     (r_s1_a_hi[HW-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                      : {1'b0, {(WIDTH-1){1'b1}}});
`else
  assign w_sum_fin = w_sum_raw;
`endif

  // Stage 2 / output registers; data holds while stalled or empty.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_sum       <= '0;
      r_c_out     <= 1'b0;
      r_ovf       <= 1'b0;
      r_zero      <= 1'b0;
      r_neg       <= 1'b0;
    end else begin
      if (w_s2_adv) begin
        r_out_valid <= 1'b1;
        r_sum       <= w_sum_fin;
        r_c_out     <= w_hi[HW];
        r_ovf       <= w_ovf;
        r_zero      <= (w_sum_fin == '0);
        r_neg       <= w_sum_fin[WIDTH-1];
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign c_out     = r_c_out;
  assign ovf       = r_ovf;
  assign zero      = r_zero;
  assign neg       = r_neg;

endmodule

// File: tb/tb_add_sub_cla_pipe.sv
// Self-checking bench for add_sub_cla_pipe (WIDTH=16): directed corner beats,
// back-to-back streaming, backpressure, random traffic and mid-flight reset,
// scored against an arithmetic reference model through an in-order queue.
module tb_add_sub_cla_pipe;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned RW    = WIDTH + 4;
  localparam longint      SMAX  = (longint'(1) <<< (WIDTH - 1)) - 1;
  localparam longint      SMIN  = -SMAX - 1;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             ovf;
  logic             zero;
  logic             neg;

  add_sub_cla_pipe #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sub       (sub),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .ovf       (ovf),
    .zero      (zero),
    .neg       (neg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int n_acc = 0;

  logic [RW-1:0] exp_q[$];
  int            acc_q[$];
  logic          lat_chk     = 1'b0;
  logic          use_dir     = 1'b0;
  logic [RW-1:0] dir_exp     = '0;
  logic          seen_in_rdy = 1'b0;
  logic          seen_acc    = 1'b0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Reference: signed/unsigned integer arithmetic, result packed {sum,c,ovf,zero,neg}.
  function automatic logic [RW-1:0] model(input logic s, input logic [WIDTH-1:0] x,
                                          input logic [WIDTH-1:0] y);
    longint           sx, sy, res;
    logic [WIDTH-1:0] r;
    logic             c, o;
    sx  = longint'($signed(x));
    sy  = longint'($signed(y));
    res = s ? (sx - sy) : (sx + sy);
    o   = (res > SMAX) || (res < SMIN);
    c   = s ? (x >= y) : ((longint'(x) + longint'(y)) >= (longint'(1) <<< WIDTH));
    r   = WIDTH'(res);
`ifdef ADD_SAT_EN
    if (o) r = (res > 0) ? WIDTH'(SMAX) : WIDTH'(SMIN);
`endif
    return {r, c, o, (r == '0), r[WIDTH-1]};
  endfunction

  function automatic logic [WIDTH-1:0] rnd_op();
    logic [WIDTH-1:0] v;
    case ($urandom_range(0, 7))
      0:       v = '0;
      1:       v = '1;
      2:       v = WIDTH'(SMAX);
      3:       v = WIDTH'(SMIN);
      4:       v = WIDTH'(1);
      default: v = WIDTH'($urandom);
    endcase
    return v;
  endfunction

  task automatic new_beat();
    sub = 1'($urandom_range(0, 1));
    a   = rnd_op();
    b   = rnd_op();
  endtask

  // One cycle: observe just after the falling edge, score, then cross the rising edge.
  task automatic tick();
    #1;
    seen_in_rdy = in_ready;
    seen_acc    = 1'b0;
    if (rst_n) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out_valid", 64'(out_valid), 64'(0));
        end else begin
          chk("result", 64'({sum, c_out, ovf, zero, neg}), 64'(exp_q[0]));
          if (out_ready) begin
            if (lat_chk) chk("latency", 64'(cyc - acc_q[0]), 64'(2));
            void'(exp_q.pop_front());
            void'(acc_q.pop_front());
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(use_dir ? dir_exp : model(sub, a, b));
        acc_q.push_back(cyc);
        n_acc++;
        seen_acc = 1'b1;
      end
    end
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      acc_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic chk_reset_state(input string tag);
    #1;
    chk({tag, "_out_valid"}, 64'(out_valid), 64'(0));
    chk({tag, "_sum"},       64'(sum),       64'(0));
    chk({tag, "_flags"},     64'({c_out, ovf, zero, neg}), 64'(0));
    chk({tag, "_in_ready"},  64'(in_ready),  64'(1));
  endtask

  task automatic drain(input string tag);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    chk(tag, 64'(exp_q.size()), 64'(0));
    repeat (2) tick();
  endtask

  logic             t_sub[7];
  logic [WIDTH-1:0] t_a[7];
  logic [WIDTH-1:0] t_b[7];
  logic [RW-1:0]    t_exp[7];

  initial begin
    t_sub[0] = 1'b0; t_a[0] = 16'h7FFF; t_b[0] = 16'h0001;
    t_sub[1] = 1'b0; t_a[1] = 16'hFFFF; t_b[1] = 16'h0001;
    t_sub[2] = 1'b0; t_a[2] = 16'h00FF; t_b[2] = 16'h0001;
    t_sub[3] = 1'b1; t_a[3] = 16'h0000; t_b[3] = 16'h0001;
    t_sub[4] = 1'b1; t_a[4] = 16'h8000; t_b[4] = 16'h0001;
    t_sub[5] = 1'b1; t_a[5] = 16'h1234; t_b[5] = 16'h1234;
    t_sub[6] = 1'b0; t_a[6] = 16'h8000; t_b[6] = 16'h8000;
`ifdef ADD_SAT_EN
    t_exp[0] = {16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0};
    t_exp[4] = {16'h8000, 1'b1, 1'b1, 1'b0, 1'b1};
    t_exp[6] = {16'h8000, 1'b1, 1'b1, 1'b0, 1'b1};
`else
    t_exp[0] = {16'h8000, 1'b0, 1'b1, 1'b0, 1'b1};
    t_exp[4] = {16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0};
    t_exp[6] = {16'h0000, 1'b1, 1'b1, 1'b1, 1'b0};
`endif
    t_exp[1] = {16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
    t_exp[2] = {16'h0100, 1'b0, 1'b0, 1'b0, 1'b0};
    t_exp[3] = {16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1};
    t_exp[5] = {16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; sub = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk_reset_state("reset");

    // Directed corner beats with known results.
    out_ready = 1'b1;
    use_dir   = 1'b1;
    for (int i = 0; i < 7; i++) begin
      sub = t_sub[i]; a = t_a[i]; b = t_b[i]; dir_exp = t_exp[i];
      in_valid = 1'b1;
      tick();
      chk("dir_accept", 64'(seen_acc), 64'(1));
    end
    use_dir = 1'b0;
    drain("dir_drain");

    // Back-to-back streaming: in_ready held high, fixed 2-cycle latency.
    lat_chk = 1'b1;
    for (int i = 0; i < 8; i++) begin
      new_beat();
      in_valid = 1'b1;
      tick();
      chk("stream_in_ready", 64'(seen_in_rdy), 64'(1));
    end
    drain("stream_drain");
    lat_chk = 1'b0;

    // Backpressure: four beats offered with out_ready low, only two fit.
    n_acc     = 0;
    out_ready = 1'b0;
    new_beat();
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i >= 2) chk("bp_in_ready", 64'(seen_in_rdy), 64'(0));
      if (seen_acc) new_beat();
    end
    chk("bp_accepts", 64'(n_acc), 64'(2));
    out_ready = 1'b1;
    for (int i = 0; i < 20 && n_acc < 4; i++) begin
      tick();
      if (seen_acc) new_beat();
    end
    chk("bp_total_accepts", 64'(n_acc), 64'(4));
    drain("bp_drain");

    // Random traffic with random backpressure; a pending beat is held until taken.
    in_valid = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!in_valid || seen_acc) begin
        in_valid = 1'($urandom_range(0, 1));
        new_beat();
      end
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain("rand_drain");

    // Fill both stages, then reset; nothing in flight may emerge afterwards.
    out_ready = 1'b0;
    new_beat();
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (seen_acc) new_beat();
    end
    chk("full_in_ready", 64'(seen_in_rdy), 64'(0));
    in_valid = 1'b0;
    rst_n    = 1'b0;
    tick();
    rst_n = 1'b1;
    chk_reset_state("midrst");
    out_ready = 1'b1;
    repeat (5) tick();
    chk("midrst_queue", 64'(exp_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/add_sub_cla_pipe.md
Name: add_sub_cla_pipe

Overview:
Parametrised two's-complement adder/subtractor built from 4-bit carry-lookahead groups, split into a 2-stage pipeline with valid/ready handshake on both sides. Stage 1 computes the lower half and registers its carry. Stage 2 computes the upper half and flags. It is the successor to the fixed-width combinational CLA adders and serves as the datapath ALU add unit.

Parameters:
WIDTH, 16, operand/result width; must be a multiple of 8, range 8..64; each half is WIDTH/2 bits built from WIDTH/8 4-bit CLA groups with group g/p lookahead.

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  operand beat valid
in_ready  output  1  block can accept a beat this cycle
sub  input  1  0: a+b, 1: a-b
a  input  WIDTH  operand A, two's complement
b  input  WIDTH  operand B, two's complement
out_valid  output  1  result beat valid
out_ready  input  1  downstream accepts result
sum  output  WIDTH  result
c_out  output  1  unsigned carry out; for sub, 1 = no borrow (a >= b unsigned)
ovf  output  1  signed overflow
zero  output  1  sum == 0
neg  output  1  sum[WIDTH-1]

Behaviour:
- One clock domain (clk). Reset is synchronous, active-low (rst_n).
- Reset (rst_n=0 at a clk edge): s1_valid=0, s2_valid=0, out_valid=0, sum=0, c_out=0, ovf=0, zero=0, neg=0. in_ready reads 1 in the cycle after reset release.
- Reset mid-operation discards all in-flight beats. No partial results appear afterwards.
- Subtract is computed as a + ~b + 1: b is inverted and the stage-1 carry-in is 1. For add, carry-in is 0.
- Stage 1 (on accept):
  - Registers lower-half sum, lower-half carry-out, upper halves of a and ~b/b, sub, and the valid bit.
- Stage 2 (on advance):
  - Computes upper-half sum from the registered operands and registered carry.
  - Registers sum, c_out, ovf, zero and neg into the output registers.
- Flag rules:
  - ovf = (a_msb == b'_msb) && (sum_msb != a_msb), where b' is the inverted b for sub.
  - zero and neg are derived from the final (post-saturation, if enabled) sum.
- Latency: 2 cycles from accept (in_valid && in_ready) to out_valid, when there is no backpressure.
- Throughput: one beat per cycle.
- Handshake:
  - s2 advance = s1_valid && (!s2_valid || out_ready).
  - in_ready = !s1_valid || s2 advance. This is combinational from out_ready; there is no combinational path from in_valid to in_ready.
  - Output beat consumed when out_valid && out_ready.
  - Outputs are held stable while out_valid && !out_ready.
- Simultaneous consume and advance in the same cycle: s2 is reloaded and out_valid stays 1.
- Simultaneous accept and advance: s1 is reloaded and s1_valid stays 1.
- Full condition: s1_valid && s2_valid && !out_ready. in_ready=0 and no state changes.
- Empty condition: out_valid=0. sum and flags hold their last values.
- Beats leave in order; none are dropped or duplicated.
- Wrap-around: sum is modulo 2^WIDTH. c_out and ovf report the wrap.

Optional Feature:
Macro ADD_SAT_EN.
- Defined: when ovf=1, sum saturates to 2^(WIDTH-1)-1 if a_msb=0, else to -2^(WIDTH-1). ovf is still reported as 1, and c_out is unchanged (raw). zero and neg follow the saturated sum.
- Undefined: sum wraps modulo 2^WIDTH with no saturation logic.

Test Plan:
- WIDTH=16, add 0x7FFF+0x0001 -> sum 0x8000, ovf=1, neg=1, c_out=0, zero=0. With ADD_SAT_EN: sum 0x7FFF, neg=0.
- Add 0xFFFF+0x0001 -> sum 0x0000, c_out=1, zero=1, ovf=0. Add 0x00FF+0x0001 -> 0x0100, which checks the carry crossing the stage boundary.
- Sub 0x0000-0x0001 -> sum 0xFFFF, c_out=0, ovf=0, neg=1. Sub 0x8000-0x0001 -> sum 0x7FFF, ovf=1; with ADD_SAT_EN: 0x8000.
- Streaming, out_ready=1, 8 back-to-back beats -> in_ready stays 1, first out_valid 2 cycles after the first accept, then one result per cycle in order.
- Backpressure: out_ready=0 while 4 beats are offered -> only 2 accepted, in_ready=0 from the following cycle, outputs held stable. Raise out_ready -> remaining beats drain in order with no loss.
- rst_n=0 for 1 cycle with s1 and s2 both full -> next cycle out_valid=0, sum=0, all flags 0, in_ready=1. The earlier beats never appear at the output.
